multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Parametrised FSM control unit for the multicycle MIPS datapath. It replaces single-cycle combinational decode with per-state control sequencing.
- It sequences FETCH/DECODE/EXEC/MEM/WB and handshakes with the memory controller (ihit/dhit).
- A bounded memory-wait timeout raises a fault.
- It sits between the datapath register file/ALU/PC and the cache/memory interface.

Parameters:
- WORD_W, 32, instruction width (bits).
- TIMEOUT, 255, max consecutive wait cycles for ihit/dhit before fault. 0 disables the timeout.
- CNT_W, 8, width of the wait counter. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous active-high reset.
- instr  in  WORD_W  imem read data; valid when ihit=1.
- ihit  in  1  instruction memory ready.
- dhit  in  1  data memory ready.
- alu_zero  in  1  ALU zero flag from EXEC.
- iren  out  1  instruction read request.
- dren  out  1  data read request.
- dwen  out  1  data write request.
- ir_load  out  1  latch instr into IR.
- pc_wen  out  1  PC update strobe.
- pc_src  out  2  0=PC+4, 1=branch target, 2=jump target, 3=rs (JR).
- regwr  out  1  register file write enable.
- regdst  out  2  0=rt, 1=rd, 2=$31.
- memtoreg  out  2  0=ALU, 1=mem data, 2=PC+4.
- alu_src  out  1  0=rt, 1=extended imm.
- extop  out  1  0=zero-extend, 1=sign-extend.
- alu_op  out  4  aluop_t encoding.
- halt  out  1  sticky halt.
- fault  out  1  sticky fault (illegal opcode or timeout).
- state  out  3  current state, for debug.

Behaviour:
- States and encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALTED=5, FAULT=6.
- Reset (async, RST=1): state=FETCH, IR=0, wait counter=0, halt=0, fault=0.
- Reset values of outputs: all outputs 0 except iren=1 (combinational from FETCH).
- RST asserted mid-instruction: immediate abort to FETCH. No partial regwr or dwen may follow.

State actions:
- FETCH:
  - iren=1.
  - On ihit: ir_load=1, pc_wen=1, pc_src=0, go to DECODE.
  - Otherwise stay and increment the wait counter.
- DECODE: decode IR.
  - J: pc_wen=1, pc_src=2, go to FETCH.
  - JAL: pc_wen=1, pc_src=2, regwr=1, regdst=2, memtoreg=2, go to FETCH.
  - HALT (opcode 0x3F): go to HALTED.
  - Undefined opcode or undefined RTYPE funct: go to FAULT.
  - All others: go to EXEC.
- EXEC: drive alu_op, alu_src and extop.
  - BEQ: pc_wen=alu_zero. BNE: pc_wen=!alu_zero. For both, pc_src=1 and go to FETCH.
  - JR: pc_wen=1, pc_src=3, go to FETCH.
  - LW/SW: go to MEM.
  - All others: go to WB.
- MEM: LW asserts dren=1, SW asserts dwen=1.
  - On dhit: LW goes to WB, SW goes to FETCH.
  - Otherwise wait.
- WB: regwr=1, one cycle only, then go to FETCH.
  - regdst=1 for RTYPE, 0 for imm/LW.
  - memtoreg=1 for LW, 0 otherwise.
- HALTED and FAULT are absorbing. All strobes are 0; only RST exits.

Decode rules:
- ALU ops:
  - alu_op=ALU_ADD for ADD/ADDU/ADDI/ADDIU/LW/SW.
  - alu_op=ALU_SUB for SUB/SUBU/BEQ/BNE.
  - ANDI→AND, ORI→OR, XORI→XOR, SLTI→SLT, SLTIU→SLTU.
  - LUI→ALU_SLL with the imm shifted by 16 in the datapath.
- extop=0 for ANDI/ORI/XORI/LUI, 1 otherwise.
- alu_src=0 for RTYPE/BEQ/BNE, 1 otherwise.

Wait counter:
- Counts consecutive no-hit cycles in FETCH or MEM.
- Clears on hit and on every state change.
- If TIMEOUT>0 and the count reaches TIMEOUT with no hit, the next state is FAULT.
- A hit in the same cycle the count reaches TIMEOUT wins (normal transition).

Other rules:
- Outside FETCH/MEM, ihit and dhit are ignored.
- A spurious dhit in FETCH has no effect.
- All control outputs are Moore/state-decoded combinational, except pc_wen in EXEC (uses alu_zero) and the handshake-qualified strobes.
- Write enables (regwr, dwen, pc_wen) are never asserted in HALTED or FAULT.

Test Plan:
- ADDU $3,$1,$2 (0x00221821), ihit held 1 → state sequence 0,1,2,4,0. Exactly one regwr cycle with regdst=1 and alu_op=ALU_ADD; pc_wen only in FETCH.
- LW with dhit delayed 3 cycles → MEM held 4 cycles with dren=1. WB then shows memtoreg=1, regdst=0; total 8 cycles.
- BNE with alu_zero=0, then a BEQ with alu_zero=0 → BNE gives pc_wen=1, pc_src=1 in EXEC; BEQ gives pc_wen=0. Each takes 3 cycles.
- TIMEOUT=4, ihit=0 forever → after 4 wait cycles state=6, fault=1, iren=0 and fault stays sticky. Repeat with ihit arriving on the 4th cycle → DECODE, no fault.
- Opcode 0x3F → state=5, halt=1, no strobes thereafter. Opcode 0x3E → fault=1.
- RST pulsed in MEM of SW with dwen=1 → outputs reset asynchronously the same cycle: dwen=0, state=0, iren=1.

Source files
------------

// File: rtl/multicycle_control_unit_if.sv
// rtl/multicycle_control_unit_if.sv - instruction/data memory handshake between control unit and cache
interface multicycle_control_unit_if #(
    parameter int WORD_W = 32
);
    logic [WORD_W-1:0] instr;
    logic              ihit;
    logic              dhit;
    logic              iren;
    logic              dren;
    logic              dwen;

    modport master (
        input  instr,
        input  ihit,
        input  dhit,
        output iren,
        output dren,
        output dwen
    );

    modport slave (
        output instr,
        output ihit,
        output dhit,
        input  iren,
        input  dren,
        input  dwen
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multicycle MIPS control FSM with bounded memory-wait fault
module multicycle_control_unit #(
    parameter int WORD_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic                             CLK,
    input  logic                             RST,
    multicycle_control_unit_if.master        bus,
    input  logic                             alu_zero,
    output logic                             ir_load,
    output logic                             pc_wen,
    output logic [1:0]                       pc_src,
    output logic                             regwr,
    output logic [1:0]                       regdst,
    output logic [1:0]                       memtoreg,
    output logic                             alu_src,
    output logic                             extop,
    output logic [3:0]                       alu_op,
    output logic                             halt,
    output logic                             fault,
    output logic [2:0]                       state
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALTED = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam logic [3:0] ALU_SLL  = 4'd0;
    localparam logic [3:0] ALU_SRL  = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_SUB  = 4'd3;
    localparam logic [3:0] ALU_AND  = 4'd4;
    localparam logic [3:0] ALU_OR   = 4'd5;
    localparam logic [3:0] ALU_XOR  = 4'd6;
    localparam logic [3:0] ALU_NOR  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    // Last count value that may still be followed by a hit; a miss here faults.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   ir_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                halt_q, fault_q;

    logic [5:0]          op, funct;
    logic [3:0]          dec_alu_op;
    logic                dec_alu_src, dec_extop, dec_legal;
    logic                waiting;
    logic                unused_ir;

    assign op        = ir_q[31:26];
    assign funct     = ir_q[5:0];
    assign unused_ir = ^ir_q;

    always_comb begin
        dec_alu_op  = ALU_ADD;
        dec_alu_src = 1'b1;
        dec_extop   = 1'b1;
        dec_legal   = 1'b1;
        unique case (op)
            OP_RTYPE: begin
                dec_alu_src = 1'b0;
                case (funct)
                    FN_SLL:          dec_alu_op = ALU_SLL;
                    FN_SRL:          dec_alu_op = ALU_SRL;
                    FN_JR:           dec_alu_op = ALU_ADD;
                    FN_ADD, FN_ADDU: dec_alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU: dec_alu_op = ALU_SUB;
                    FN_AND:          dec_alu_op = ALU_AND;
                    FN_OR:           dec_alu_op = ALU_OR;
                    FN_XOR:          dec_alu_op = ALU_XOR;
                    FN_NOR:          dec_alu_op = ALU_NOR;
                    FN_SLT:          dec_alu_op = ALU_SLT;
                    FN_SLTU:         dec_alu_op = ALU_SLTU;
                    default:         dec_legal  = 1'b0;
                endcase
            end
            OP_BEQ, OP_BNE: begin
                dec_alu_op  = ALU_SUB;
                dec_alu_src = 1'b0;
            end
            OP_J, OP_JAL, OP_HALT, OP_ADDI, OP_ADDIU, OP_LW, OP_SW: ;
            OP_SLTI:  dec_alu_op = ALU_SLT;
            OP_SLTIU: dec_alu_op = ALU_SLTU;
            OP_ANDI: begin
                dec_alu_op = ALU_AND;
                dec_extop  = 1'b0;
            end
            OP_ORI: begin
                dec_alu_op = ALU_OR;
                dec_extop  = 1'b0;
            end
            OP_XORI: begin
                dec_alu_op = ALU_XOR;
                dec_extop  = 1'b0;
            end
            OP_LUI: begin
                dec_alu_op = ALU_SLL;
                dec_extop  = 1'b0;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_FETCH;
            ir_q    <= '0;
            cnt_q   <= '0;
            halt_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (ir_load)
                ir_q <= bus.instr;
            if (state_d == S_HALTED)
                halt_q <= 1'b1;
            if (state_d == S_FAULT)
                fault_q <= 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        waiting  = 1'b0;
        bus.iren = 1'b0;
        bus.dren = 1'b0;
        bus.dwen = 1'b0;
        ir_load  = 1'b0;
        pc_wen   = 1'b0;
        pc_src   = 2'd0;
        regwr    = 1'b0;
        regdst   = 2'd0;
        memtoreg = 2'd0;
        alu_src  = 1'b0;
        extop    = 1'b0;
        alu_op   = 4'd0;

        // The ALU operands stay stable through MEM and WB so the result is held.
        if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
            alu_op  = dec_alu_op;
            alu_src = dec_alu_src;
            extop   = dec_extop;
        end

        unique case (state_q)
            S_FETCH: begin
                bus.iren = 1'b1;
                if (bus.ihit) begin
                    ir_load = 1'b1;
                    pc_wen  = 1'b1;
                    state_d = S_DECODE;
                end else begin
                    waiting = 1'b1;
                end
            end
            S_DECODE: begin
                if (op == OP_J) begin
                    pc_wen  = 1'b1;
                    pc_src  = 2'd2;
                    state_d = S_FETCH;
                end else if (op == OP_JAL) begin
                    pc_wen   = 1'b1;
                    pc_src   = 2'd2;
                    regwr    = 1'b1;
                    regdst   = 2'd2;
                    memtoreg = 2'd2;
                    state_d  = S_FETCH;
                end else if (op == OP_HALT) begin
                    state_d = S_HALTED;
                end else if (!dec_legal) begin
                    state_d = S_FAULT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (op == OP_BEQ || op == OP_BNE) begin
                    pc_src  = 2'd1;
                    pc_wen  = (op == OP_BEQ) ? alu_zero : !alu_zero;
                    state_d = S_FETCH;
                end else if (op == OP_RTYPE && funct == FN_JR) begin
                    pc_wen  = 1'b1;
                    pc_src  = 2'd3;
                    state_d = S_FETCH;
                end else if (op == OP_LW || op == OP_SW) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                bus.dren = (op == OP_LW);
                bus.dwen = (op == OP_SW);
                if (bus.dhit)
                    state_d = (op == OP_LW) ? S_WB : S_FETCH;
                else
                    waiting = 1'b1;
            end
            S_WB: begin
                regwr    = 1'b1;
                regdst   = (op == OP_RTYPE) ? 2'd1 : 2'd0;
                memtoreg = (op == OP_LW) ? 2'd1 : 2'd0;
                state_d  = S_FETCH;
            end
            S_HALTED, S_FAULT: ;
            default: state_d = S_FAULT;
        endcase

        // A hit on the last permitted cycle never reaches here, so it wins over the timeout.
        if (waiting) begin
            if (TIMEOUT > 0 && cnt_q == CNT_LAST)
                state_d = S_FAULT;
            else
                cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign halt  = halt_q;
    assign fault = fault_q;
    assign state = state_q;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - scoreboard bench for the multicycle control unit
module tb_multicycle_control_unit;
    localparam int TO = 4;

    typedef struct packed {
        logic [2:0] state;
        logic       iren;
        logic       dren;
        logic       dwen;
        logic       ir_load;
        logic       pc_wen;
        logic [1:0] pc_src;
        logic       regwr;
        logic [1:0] regdst;
        logic [1:0] memtoreg;
        logic       alu_src;
        logic       extop;
        logic [3:0] alu_op;
        logic       halt;
        logic       fault;
    } ctl_t;

    typedef enum {K_R, K_JR, K_J, K_JAL, K_BEQ, K_BNE, K_LW, K_SW, K_IMM, K_HALT, K_ILL} kind_t;

    localparam logic [5:0] OPS [15] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
                                        6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
    localparam logic [5:0] FNS [13] = '{6'h00, 6'h02, 6'h08, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
                                        6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};

    logic       CLK = 1'b1;
    logic       RST = 1'b0;
    logic       alu_zero;
    logic       ir_load, pc_wen, regwr, alu_src, extop, halt, fault;
    logic [1:0] pc_src, regdst, memtoreg;
    logic [3:0] alu_op;
    logic [2:0] state;

    int vectors = 0;
    int miscompares = 0;
    ctl_t sb[$];

    multicycle_control_unit_if #(.WORD_W(32)) bus ();

    multicycle_control_unit #(.WORD_W(32), .TIMEOUT(TO), .CNT_W(3)) dut (
        .CLK(CLK), .RST(RST), .bus(bus), .alu_zero(alu_zero),
        .ir_load(ir_load), .pc_wen(pc_wen), .pc_src(pc_src), .regwr(regwr),
        .regdst(regdst), .memtoreg(memtoreg), .alu_src(alu_src), .extop(extop),
        .alu_op(alu_op), .halt(halt), .fault(fault), .state(state)
    );

    always #5 CLK = ~CLK;

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic ctl_t sample();
        ctl_t g;
        g.state = state;      g.iren = bus.iren;     g.dren = bus.dren;     g.dwen = bus.dwen;
        g.ir_load = ir_load;  g.pc_wen = pc_wen;     g.pc_src = pc_src;     g.regwr = regwr;
        g.regdst = regdst;    g.memtoreg = memtoreg; g.alu_src = alu_src;   g.extop = extop;
        g.alu_op = alu_op;    g.halt = halt;         g.fault = fault;
        return g;
    endfunction

    function automatic kind_t classify(input logic [31:0] ins);
        logic [5:0] op = ins[31:26];
        logic [5:0] fn = ins[5:0];
        case (op)
            6'h00: begin
                if (fn == 6'h08) return K_JR;
                if (fn inside {6'h00, 6'h02, [6'h20:6'h27], 6'h2A, 6'h2B}) return K_R;
                return K_ILL;
            end
            6'h02: return K_J;
            6'h03: return K_JAL;
            6'h04: return K_BEQ;
            6'h05: return K_BNE;
            6'h23: return K_LW;
            6'h2B: return K_SW;
            6'h3F: return K_HALT;
            default: return (op inside {[6'h08:6'h0F]}) ? K_IMM : K_ILL;
        endcase
    endfunction

    // ALU selection straight from the instruction table: 0 SLL,1 SRL,2 ADD,3 SUB,4 AND,5 OR,6 XOR,7 NOR,8 SLT,9 SLTU
    function automatic ctl_t with_alu(input ctl_t e, input logic [31:0] ins);
        logic [5:0] op = ins[31:26];
        logic [5:0] fn = ins[5:0];
        kind_t k = classify(ins);
        e.alu_op = 4'd2;
        if (k == K_R) begin
            case (fn)
                6'h00: e.alu_op = 4'd0;
                6'h02: e.alu_op = 4'd1;
                6'h22, 6'h23: e.alu_op = 4'd3;
                6'h24: e.alu_op = 4'd4;
                6'h25: e.alu_op = 4'd5;
                6'h26: e.alu_op = 4'd6;
                6'h27: e.alu_op = 4'd7;
                6'h2A: e.alu_op = 4'd8;
                6'h2B: e.alu_op = 4'd9;
                default: e.alu_op = 4'd2;
            endcase
        end else if (k == K_BEQ || k == K_BNE) e.alu_op = 4'd3;
        else if (op == 6'h0A) e.alu_op = 4'd8;
        else if (op == 6'h0B) e.alu_op = 4'd9;
        else if (op == 6'h0C) e.alu_op = 4'd4;
        else if (op == 6'h0D) e.alu_op = 4'd5;
        else if (op == 6'h0E) e.alu_op = 4'd6;
        else if (op == 6'h0F) e.alu_op = 4'd0;
        e.alu_src = !(k inside {K_R, K_JR, K_BEQ, K_BNE});
        e.extop   = !(op inside {6'h0C, 6'h0D, 6'h0E, 6'h0F});
        return e;
    endfunction

    function automatic ctl_t exp_state(input int s);
        ctl_t e = '0;
        e.state = 3'(s);
        e.iren  = (s == 0);
        e.halt  = (s == 5);
        e.fault = (s == 6);
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins = $urandom;
        int pick = $urandom_range(0, 19);
        if (pick == 0) ins[31:26] = 6'h3F;
        else if (pick == 1) ins[31:26] = 6'h3E;
        else if (pick == 2) begin ins[31:26] = 6'h00; ins[5:0] = 6'h01; end
        else begin
            ins[31:26] = OPS[$urandom_range(0, 14)];
            if (ins[31:26] == 6'h00) ins[5:0] = FNS[$urandom_range(0, 12)];
        end
        return ins;
    endfunction

    task automatic step(input logic rst, input logic [31:0] ins, input logic ih, input logic dh,
                        input logic z, input ctl_t e);
        RST = rst; bus.instr = ins; bus.ihit = ih; bus.dhit = dh; alu_zero = z;
        sb.push_back(e);
        @(posedge CLK); #1;
    endtask

    task automatic absorb(input int s);
        for (int i = 0; i < 3; i++) step(1'b0, $urandom, rb(), rb(), rb(), exp_state(s));
    endtask

    task automatic do_reset();
        for (int i = 0; i < 2; i++) step(1'b1, $urandom, 1'b0, rb(), rb(), exp_state(0));
    endtask

    task automatic run_instr(input logic [31:0] ins, input int fw, input int mw, input int zf);
        kind_t k = classify(ins);
        ctl_t e;
        logic z;
        for (int i = 0; i < fw && i < TO; i++) step(1'b0, $urandom, 1'b0, rb(), rb(), exp_state(0));
        if (fw >= TO) begin absorb(6); do_reset(); return; end
        e = exp_state(0); e.ir_load = 1'b1; e.pc_wen = 1'b1;
        step(1'b0, ins, 1'b1, rb(), rb(), e);
        e = exp_state(1);
        if (k == K_J || k == K_JAL) begin
            e.pc_wen = 1'b1; e.pc_src = 2'd2;
            if (k == K_JAL) begin e.regwr = 1'b1; e.regdst = 2'd2; e.memtoreg = 2'd2; end
        end
        step(1'b0, $urandom, rb(), rb(), rb(), e);
        if (k == K_J || k == K_JAL) return;
        if (k == K_HALT) begin absorb(5); do_reset(); return; end
        if (k == K_ILL) begin absorb(6); do_reset(); return; end
        z = (zf < 0) ? rb() : zf[0];
        e = with_alu(exp_state(2), ins);
        if (k == K_BEQ) begin e.pc_src = 2'd1; e.pc_wen = z; end
        if (k == K_BNE) begin e.pc_src = 2'd1; e.pc_wen = !z; end
        if (k == K_JR) begin e.pc_src = 2'd3; e.pc_wen = 1'b1; end
        step(1'b0, $urandom, rb(), rb(), z, e);
        if (k inside {K_BEQ, K_BNE, K_JR}) return;
        if (k == K_LW || k == K_SW) begin
            e = with_alu(exp_state(3), ins);
            e.dren = (k == K_LW); e.dwen = (k == K_SW);
            for (int i = 0; i < mw && i < TO; i++) step(1'b0, $urandom, rb(), 1'b0, rb(), e);
            if (mw >= TO) begin absorb(6); do_reset(); return; end
            step(1'b0, $urandom, rb(), 1'b1, rb(), e);
            if (k == K_SW) return;
        end
        e = with_alu(exp_state(4), ins);
        e.regwr = 1'b1;
        e.regdst = (k == K_R) ? 2'd1 : 2'd0;
        e.memtoreg = (k == K_LW) ? 2'd1 : 2'd0;
        step(1'b0, $urandom, rb(), rb(), rb(), e);
    endtask

    task automatic async_reset_in_sw();
        logic [31:0] ins = 32'hAC22_0008;
        ctl_t e, g;
        e = exp_state(0); e.ir_load = 1'b1; e.pc_wen = 1'b1;
        step(1'b0, ins, 1'b1, 1'b0, 1'b0, e);
        step(1'b0, $urandom, 1'b0, 1'b0, 1'b0, exp_state(1));
        step(1'b0, $urandom, 1'b0, 1'b0, 1'b0, with_alu(exp_state(2), ins));
        e = with_alu(exp_state(3), ins); e.dwen = 1'b1;
        RST = 1'b0; bus.ihit = 1'b0; bus.dhit = 1'b0;
        sb.push_back(e);
        @(negedge CLK); #1;
        RST = 1'b1;
        #1;
        g = sample();
        vectors++;
        if (g !== exp_state(0)) begin
            miscompares++;
            $display("FAIL async_rst got=%h exp=%h", g, exp_state(0));
        end
        @(posedge CLK); #1;
        step(1'b1, $urandom, 1'b0, 1'b0, 1'b0, exp_state(0));
    endtask

    initial begin : monitor
        ctl_t e, g;
        forever begin
            @(negedge CLK);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                g = sample();
                vectors++;
                if (g !== e) begin
                    miscompares++;
                    $display("FAIL ctl t=%0t state got=%0d exp=%0d vec got=%h exp=%h", $time, g.state, e.state, g, e);
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : driver
        bus.instr = '0; bus.ihit = 1'b0; bus.dhit = 1'b0; alu_zero = 1'b0;
        do_reset();
        run_instr(32'h0022_1821, 0, 0, -1);
        run_instr(32'h8C22_0004, 1, 3, -1);
        run_instr(32'h1422_0003, 0, 0, 0);
        run_instr(32'h1022_0003, 0, 0, 0);
        run_instr(32'h0022_1821, 4, 0, -1);
        run_instr(32'h0022_1821, 3, 0, -1);
        run_instr(32'h8C22_0004, 0, 4, -1);
        run_instr(32'hAC22_0008, 2, 3, -1);
        run_instr(32'h0C00_0010, 0, 0, -1);
        run_instr(32'h0800_0010, 1, 0, -1);
        run_instr(32'h03E0_0008, 0, 0, -1);
        run_instr(32'h3C01_1234, 0, 0, -1);
        run_instr(32'h3022_0FFF, 2, 0, -1);
        run_instr(32'hFC00_0000, 0, 0, -1);
        run_instr(32'hF800_0000, 0, 0, -1);
        run_instr(32'h0000_0001, 0, 0, -1);
        async_reset_in_sw();
        for (int n = 0; n < 120; n++) begin
            run_instr(rand_instr(),
                      ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, TO - 1),
                      ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, TO - 1), -1);
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain left=%0d exp=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
